regfile: RTL and testbench

Parametrised multi-port register bank that replaces ad-hoc banks of single `register` instances in the datapath. It provides one synchronous write port, two combinational read ports and optional write-to-read bypass. It also has an optional hardwired-zero register 0 and a sequenced bulk-clear engine with a busy/done handshake for the control unit.

---
 rtl/regfile_if.sv | 29 ++
 rtl/regfile.sv | 110 +++++++++++
 tb/tb_regfile.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_if.sv
// Bundle of write, dual-read and bulk-clear handshake signals for regfile.
// The control unit connects through master and the bank through slave.
interface regfile_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic [AW-1:0]    raddr_a;
  logic [WIDTH-1:0] rdata_a;
  logic [AW-1:0]    raddr_b;
  logic [WIDTH-1:0] rdata_b;
  logic             clr_req;
  logic             clr_busy;
  logic             clr_done;

  modport master (
    output we, waddr, wdata, raddr_a, raddr_b, clr_req,
    input  rdata_a, rdata_b, clr_busy, clr_done
  );

  modport slave (
    input  we, waddr, wdata, raddr_a, raddr_b, clr_req,
    output rdata_a, rdata_b, clr_busy, clr_done
  );
endinterface

// File: rtl/regfile.sv
// Register bank with one synchronous write port, two combinational read ports,
// optional write bypass and hardwired zero register, and a sequenced bulk clear.
module regfile #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic      clk,
  input  logic      rst,
  regfile_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic write_ok;
  logic fwd_ok;

  // Writes are locked out only in CLEAR; DONE already accepts them.
  assign write_ok = bus.we && (state_q != ST_CLEAR)
                    && !((ZERO_REG != 0) && (bus.waddr == '0));
  assign fwd_ok   = (BYPASS != 0) && bus.we && (state_q != ST_CLEAR);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.clr_req) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
        end
      end
      ST_CLEAR: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    if (state_q == ST_CLEAR) begin
      mem_d[idx_q] = '0;
    end else if (write_ok) begin
      mem_d[bus.waddr] = bus.wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Zero-register override is applied last so it also masks the bypass path.
  always_comb begin
    bus.rdata_a = mem_q[bus.raddr_a];
    if (fwd_ok && (bus.waddr == bus.raddr_a)) begin
      bus.rdata_a = bus.wdata;
    end
    if ((ZERO_REG != 0) && (bus.raddr_a == '0)) begin
      bus.rdata_a = '0;
    end
  end

  always_comb begin
    bus.rdata_b = mem_q[bus.raddr_b];
    if (fwd_ok && (bus.waddr == bus.raddr_b)) begin
      bus.rdata_b = bus.wdata;
    end
    if ((ZERO_REG != 0) && (bus.raddr_b == '0)) begin
      bus.rdata_b = '0;
    end
  end

  assign bus.clr_busy = (state_q == ST_CLEAR);
  assign bus.clr_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_regfile.sv
// Drives two regfile variants (default, and zero-reg without bypass) with the
// same stimulus and compares both against an array-based reference model.
module tb_regfile;
  localparam int W = 8;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  regfile_if #(.WIDTH(W), .DEPTH(D)) bus0 ();
  regfile_if #(.WIDTH(W), .DEPTH(D)) bus1 ();

  regfile #(.WIDTH(W), .DEPTH(D), .ZERO_REG(0), .BYPASS(1)) u0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  regfile #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1), .BYPASS(0)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: register contents plus the edge number at which the
  // most recent clear request was taken.
  int          zr_cfg [2] = '{0, 1};
  int          by_cfg [2] = '{1, 0};
  logic [W-1:0] m [2][D];
  int          cyc       = 0;
  int          clr_start = -1;

  logic         cur_we;
  logic [2:0]   cur_waddr;
  logic [W-1:0] cur_wdata;
  logic [2:0]   cur_ra;
  logic [2:0]   cur_rb;
  logic         cur_req;

  function automatic logic m_busy();
    return (clr_start >= 0) && (cyc - clr_start >= 0) && (cyc - clr_start <= D - 1);
  endfunction

  function automatic logic m_done();
    return (clr_start >= 0) && (cyc - clr_start == D);
  endfunction

  function automatic logic [W-1:0] exp_rd(input int d, input logic [2:0] a);
    if (zr_cfg[d] != 0 && a == 3'd0) return '0;
    if (by_cfg[d] != 0 && cur_we && !m_busy() && cur_waddr == a) return cur_wdata;
    return m[d][a];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < D; i++) m[d][i] = '0;
    clr_start = -1;
  endtask

  task automatic set_in(input logic we, input logic [2:0] wa, input logic [W-1:0] wd,
                        input logic [2:0] ra, input logic [2:0] rb, input logic req);
    cur_we = we; cur_waddr = wa; cur_wdata = wd; cur_ra = ra; cur_rb = rb; cur_req = req;
    bus0.we = we; bus0.waddr = wa; bus0.wdata = wd;
    bus0.raddr_a = ra; bus0.raddr_b = rb; bus0.clr_req = req;
    bus1.we = we; bus1.waddr = wa; bus1.wdata = wd;
    bus1.raddr_a = ra; bus1.raddr_b = rb; bus1.clr_req = req;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_assert++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/u0.rdata_a"}, bus0.rdata_a, exp_rd(0, cur_ra));
    chk({tag, "/u0.rdata_b"}, bus0.rdata_b, exp_rd(0, cur_rb));
    chk({tag, "/u0.busy"}, {7'd0, bus0.clr_busy}, {7'd0, m_busy()});
    chk({tag, "/u0.done"}, {7'd0, bus0.clr_done}, {7'd0, m_done()});
    chk({tag, "/u1.rdata_a"}, bus1.rdata_a, exp_rd(1, cur_ra));
    chk({tag, "/u1.rdata_b"}, bus1.rdata_b, exp_rd(1, cur_rb));
    chk({tag, "/u1.busy"}, {7'd0, bus1.clr_busy}, {7'd0, m_busy()});
    chk({tag, "/u1.done"}, {7'd0, bus1.clr_done}, {7'd0, m_done()});
  endtask

  // Advance one clock edge, applying the model's rules to the inputs held
  // during the cycle that just ended.
  task automatic tick();
    int new_start;
    int k;
    new_start = -1;
    if (!rst) begin
      k = cyc - clr_start;
      if (m_busy()) begin
        for (int d = 0; d < 2; d++) m[d][k] = '0;
      end else if (cur_we) begin
        for (int d = 0; d < 2; d++)
          if (!(zr_cfg[d] != 0 && cur_waddr == 3'd0)) m[d][cur_waddr] = cur_wdata;
      end
      if (!m_busy() && !m_done() && cur_req) new_start = cyc + 1;
    end
    @(posedge clk);
    cyc++;
    if (new_start >= 0) clr_start = new_start;
    #1;
  endtask

  initial begin
    model_reset();
    set_in(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1 check_all("reset");

    // Basic writes and dual reads
    set_in(1'b1, 3'd3, 8'hA5, 3'd0, 3'd0, 1'b0); tick();
    set_in(1'b1, 3'd7, 8'h5A, 3'd0, 3'd0, 1'b0); tick();
    set_in(1'b0, 3'd0, 8'h00, 3'd3, 3'd7, 1'b0); #1 check_all("rd_3_7");
    chk("rd_a_const", bus0.rdata_a, 8'hA5);
    chk("rd_b_const", bus0.rdata_b, 8'h5A);
    set_in(1'b0, 3'd0, 8'h00, 3'd3, 3'd3, 1'b0); #1 check_all("rd_same");

    // Bypass vs registered path
    set_in(1'b1, 3'd2, 8'h11, 3'd0, 3'd0, 1'b0); tick();
    set_in(1'b1, 3'd2, 8'h22, 3'd2, 3'd2, 1'b0); #1 check_all("bypass");
    chk("bypass_u0", bus0.rdata_a, 8'h22);
    chk("nobypass_u1", bus1.rdata_a, 8'h11);
    tick();
    set_in(1'b0, 3'd0, 8'h00, 3'd2, 3'd3, 1'b0); #1 check_all("after_wr");

    // Register 0 writes and bypass
    set_in(1'b1, 3'd0, 8'hFF, 3'd1, 3'd1, 1'b0); tick();
    set_in(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0); #1 check_all("zero_rd");
    set_in(1'b1, 3'd0, 8'h77, 3'd0, 3'd2, 1'b0); #1 check_all("zero_byp");
    chk("zero_byp_u1", bus1.rdata_a, 8'h00);
    tick();

    // Asynchronous reset between edges
    set_in(1'b0, 3'd0, 8'h00, 3'd3, 3'd7, 1'b0);
    #1 rst = 1'b1;
    model_reset();
    #1 check_all("async_rst");
    #1 rst = 1'b0;
    tick();

    // Fill, then full clear sequence with writes to r5 in busy and done
    for (int i = 0; i < D; i++) begin
      set_in(1'b1, 3'(i), 8'h10 + 8'(i), 3'd0, 3'd0, 1'b0);
      tick();
    end
    set_in(1'b0, 3'd0, 8'h00, 3'd5, 3'd7, 1'b1); #1 check_all("clr_req");
    tick();
    for (int i = 0; i < D; i++) begin
      set_in(i == 6, 3'd5, 8'hEE, 3'(i), 3'(i + 1), 1'b0);
      #1 check_all("clr_busy");
      tick();
    end
    set_in(1'b1, 3'd5, 8'h99, 3'd4, 3'd5, 1'b0); #1 check_all("clr_done");
    tick();
    set_in(1'b0, 3'd0, 8'h00, 3'd5, 3'd6, 1'b0); #1 check_all("post_clr");
    chk("r5_done_wr", bus0.rdata_a, 8'h99);

    // Reset in the middle of a clear
    for (int i = 0; i < D; i++) begin
      set_in(1'b1, 3'(i), 8'h30 + 8'(i), 3'd0, 3'd0, 1'b0);
      tick();
    end
    set_in(1'b0, 3'd0, 8'h00, 3'd6, 3'd7, 1'b1); tick();
    set_in(1'b0, 3'd0, 8'h00, 3'd6, 3'd7, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    #1 check_all("clr_idx4");
    rst = 1'b1;
    model_reset();
    #1 check_all("rst_mid_clr");
    #1 rst = 1'b0;
    for (int i = 0; i < D + 4; i++) begin
      tick();
      check_all("no_done");
    end
    set_in(1'b1, 3'd4, 8'h44, 3'd4, 3'd0, 1'b1); tick();
    set_in(1'b0, 3'd0, 8'h00, 3'd4, 3'd0, 1'b0);
    for (int i = 0; i < D + 2; i++) begin
      check_all("reclear");
      tick();
    end

    // Held request: back-to-back sequences
    set_in(1'b0, 3'd0, 8'h00, 3'd1, 3'd2, 1'b1);
    for (int i = 0; i < 2 * (D + 2) + 3; i++) begin
      tick();
      check_all("b2b");
    end
    set_in(1'b0, 3'd0, 8'h00, 3'd1, 3'd2, 1'b0);
    for (int i = 0; i < D + 2; i++) tick();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
             3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
             $urandom_range(0, 15) == 0);
      #1 check_all("rand");
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
